// File: rtl/regfile_wport_sched.sv
// Write-port scheduler for the 32x32 integer register bank.
// The pipeline WB stage and the multi-cycle MDU share one write port.
// MDU results wait in a small FIFO. A starvation counter makes sure that
// FIFO still drains while WB is busy. A pending-write scoreboard stalls ID
// on hazards against MDU destinations that are still in flight.
module regfile_wport_sched #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                     clock,
   input  logic                     rst_n,
   input  logic                     wb_valid,
   input  logic [4:0]               wb_rd,
   input  logic [31:0]              wb_data,
   output logic                     wb_hold,
   input  logic                     mdu_valid,
   input  logic [4:0]               mdu_rd,
   input  logic [31:0]              mdu_data,
   output logic                     mdu_ready,
   input  logic                     issue_valid,
   input  logic [4:0]               issue_rd,
   input  logic [4:0]               id_rs1,
   input  logic [4:0]               id_rs2,
   input  logic [4:0]               id_rd,
   output logic                     id_stall,
   output logic                     regWEn,
   output logic [4:0]               addr_D,
   output logic [31:0]              data_D,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [4:0]    r_fifoRd   [DEPTH];
   logic [31:0]   r_fifoData [DEPTH];
   logic [AW-1:0] r_wrPtr;
   logic [AW-1:0] r_rdPtr;
   logic [CW-1:0] r_count;
   logic [31:0]   r_pending;
   logic [SW-1:0] r_starveCnt;

   logic          w_empty;
   logic          w_wbLive;
   logic          w_fifoGnt;
   logic          w_push;
   logic          w_pop;
   logic          w_wbGranted;
   logic [4:0]    w_headRd;
   logic [31:0]   w_headData;
   logic [31:0]   w_pendingNext;

   assign w_empty     = (r_count == '0);
   assign mdu_ready   = (r_count < CW'(DEPTH));
   assign w_wbLive    = wb_valid && (wb_rd != 5'd0);
   assign w_fifoGnt   = !w_empty && (!w_wbLive || (r_starveCnt >= SW'(STARVE_LIMIT)));
   assign w_pop       = w_fifoGnt;
   // Results for x0 are dropped here and never take a FIFO slot.
   assign w_push      = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
   assign w_wbGranted = w_wbLive && !w_fifoGnt;
   assign w_headRd    = r_fifoRd[r_rdPtr];
   assign w_headData  = r_fifoData[r_rdPtr];
   assign wb_hold     = w_wbLive && w_fifoGnt;
   assign fifo_count  = r_count;
   assign id_stall    = r_pending[id_rs1] | r_pending[id_rs2] | r_pending[id_rd];

   // Drive the register bank port. A granted FIFO head beats WB; otherwise a live WB write uses the port.
   always_comb begin
      regWEn = 1'b0;
      addr_D = 5'd0;
      data_D = 32'd0;
      if (w_fifoGnt) begin
         regWEn = 1'b1;
         addr_D = w_headRd;
         data_D = w_headData;
      end else if (w_wbLive) begin
         regWEn = 1'b1;
         addr_D = wb_rd;
         data_D = wb_data;
      end
   end

   // Update the scoreboard. A pop clears its bit, but an issue in the same cycle sets it again. x0 is never pending.
   always_comb begin
      w_pendingNext = r_pending;
      if (w_pop) begin
         w_pendingNext[w_headRd] = 1'b0;
      end
      if (issue_valid && (issue_rd != 5'd0)) begin
         w_pendingNext[issue_rd] = 1'b1;
      end
      w_pendingNext[0] = 1'b0;
   end

   // FIFO storage. It has no reset because the count and pointers say which entries are valid.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fifoRd[r_wrPtr]   <= mdu_rd;
         r_fifoData[r_wrPtr] <= mdu_data;
      end
   end

   // FIFO pointers and occupancy. The pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Starvation counter: counts WB grants made while results wait in the FIFO.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_starveCnt <= '0;
      end else if (w_empty || w_fifoGnt) begin
         r_starveCnt <= '0;
      end else if (w_wbGranted && (r_starveCnt < SW'(STARVE_LIMIT))) begin
         r_starveCnt <= r_starveCnt + SW'(1);
      end
   end

   // Pending-write scoreboard register.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= 32'd0;
      end else begin
         r_pending <= w_pendingNext;
      end
   end

endmodule

// File: tb/tb_regfile_wport_sched.sv
// Directed self-checking bench for regfile_wport_sched.
// Each test drives inputs just after a rising edge and checks outputs 1 ns later.
`timescale 1ns/1ps
module tb_regfile_wport_sched;

   logic        clock;
   logic        rst_n;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_hold;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        mdu_ready;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [4:0]  id_rd;
   logic        id_stall;
   logic        regWEn;
   logic [4:0]  addr_D;
   logic [31:0] data_D;
   logic [1:0]  fifo_count;

   int checks   = 0;
   int failures = 0;

   regfile_wport_sched #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clock(clock), .rst_n(rst_n),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_hold(wb_hold),
      .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_stall(id_stall),
      .regWEn(regWEn), .addr_D(addr_D), .data_D(data_D), .fifo_count(fifo_count)
   );

   // Free-running 100 MHz clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic clearInputs();
      wb_valid = 0; wb_rd = 0; wb_data = 0;
      mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
      issue_valid = 0; issue_rd = 0;
      id_rs1 = 0; id_rs2 = 0; id_rd = 0;
   endtask

   // Move to 1 ns after the next rising edge, which is where the bench drives inputs.
   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clearInputs();
      repeat (2) nextCycle();
      #1;
      checks++; if (regWEn !== 1'b0) begin failures++; $display("[TB] FAIL reset_wen got=%0b exp=0", regWEn); end
      checks++; if (mdu_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%0b exp=1", mdu_ready); end
      checks++; if (fifo_count !== 2'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", fifo_count); end
      checks++; if (id_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%0b exp=0", id_stall); end
      checks++; if (wb_hold !== 1'b0) begin failures++; $display("[TB] FAIL reset_hold got=%0b exp=0", wb_hold); end
      @(negedge clock);
      rst_n = 1'b1;
   endtask

   task automatic test_mdu_push();
      nextCycle();
      issue_valid = 1; issue_rd = 5'd5;
      nextCycle();
      issue_valid = 0;
      mdu_valid = 1; mdu_rd = 5'd5; mdu_data = 32'hDEAD; id_rs1 = 5'd5;
      #1;
      checks++; if (regWEn !== 1'b0) begin failures++; $display("[TB] FAIL push_nopass got=%0b exp=0", regWEn); end
      checks++; if (id_stall !== 1'b1) begin failures++; $display("[TB] FAIL push_stall5 got=%0b exp=1", id_stall); end
      nextCycle();
      mdu_valid = 0;
      #1;
      checks++; if (regWEn !== 1'b1) begin failures++; $display("[TB] FAIL push_wen got=%0b exp=1", regWEn); end
      checks++; if (addr_D !== 5'd5) begin failures++; $display("[TB] FAIL push_addr got=%0d exp=5", addr_D); end
      checks++; if (data_D !== 32'hDEAD) begin failures++; $display("[TB] FAIL push_data got=%0h exp=dead", data_D); end
      checks++; if (fifo_count !== 2'd1) begin failures++; $display("[TB] FAIL push_count got=%0d exp=1", fifo_count); end
      nextCycle();
      #1;
      checks++; if (id_stall !== 1'b0) begin failures++; $display("[TB] FAIL push_clear got=%0b exp=0", id_stall); end
      checks++; if (regWEn !== 1'b0) begin failures++; $display("[TB] FAIL push_idle got=%0b exp=0", regWEn); end
      clearInputs();
   endtask

   task automatic test_scoreboard();
      nextCycle();
      issue_valid = 1; issue_rd = 5'd7; id_rs2 = 5'd7;
      #1;
      checks++; if (id_stall !== 1'b0) begin failures++; $display("[TB] FAIL sb_early got=%0b exp=0", id_stall); end
      nextCycle();
      issue_valid = 1; issue_rd = 5'd0;
      #1;
      checks++; if (id_stall !== 1'b1) begin failures++; $display("[TB] FAIL sb_rs2 got=%0b exp=1", id_stall); end
      nextCycle();
      issue_valid = 0; id_rs2 = 5'd0;
      #1;
      checks++; if (id_stall !== 1'b0) begin failures++; $display("[TB] FAIL sb_x0 got=%0b exp=0", id_stall); end
      id_rd = 5'd7; mdu_valid = 1; mdu_rd = 5'd7; mdu_data = 32'h77;
      #1;
      checks++; if (id_stall !== 1'b1) begin failures++; $display("[TB] FAIL sb_rd got=%0b exp=1", id_stall); end
      nextCycle();
      mdu_valid = 0; id_rd = 5'd0; id_rs2 = 5'd7;
      #1;
      checks++; if (addr_D !== 5'd7 || regWEn !== 1'b1) begin failures++; $display("[TB] FAIL sb_write got=%0d/%0b exp=7/1", addr_D, regWEn); end
      checks++; if (id_stall !== 1'b1) begin failures++; $display("[TB] FAIL sb_hold got=%0b exp=1", id_stall); end
      nextCycle();
      #1;
      checks++; if (id_stall !== 1'b0) begin failures++; $display("[TB] FAIL sb_release got=%0b exp=0", id_stall); end
      id_rs2 = 0;
      mdu_valid = 1; mdu_rd = 5'd9; mdu_data = 32'h99;
      nextCycle();
      mdu_valid = 0; issue_valid = 1; issue_rd = 5'd9;
      #1;
      checks++; if (addr_D !== 5'd9) begin failures++; $display("[TB] FAIL sb_pop9 got=%0d exp=9", addr_D); end
      nextCycle();
      issue_valid = 0; id_rs1 = 5'd9;
      #1;
      checks++; if (id_stall !== 1'b1) begin failures++; $display("[TB] FAIL sb_setwins got=%0b exp=1", id_stall); end
      mdu_valid = 1; mdu_rd = 5'd9; mdu_data = 32'h9;
      nextCycle();
      mdu_valid = 0;
      nextCycle();
      #1;
      checks++; if (id_stall !== 1'b0) begin failures++; $display("[TB] FAIL sb_clear9 got=%0b exp=0", id_stall); end
      clearInputs();
   endtask

   task automatic test_starvation();
      nextCycle();
      wb_valid = 1; wb_rd = 5'd1; wb_data = 32'h100;
      mdu_valid = 1; mdu_rd = 5'd3; mdu_data = 32'h33;
      #1;
      checks++; if (addr_D !== 5'd1 || regWEn !== 1'b1) begin failures++; $display("[TB] FAIL starve_first got=%0d exp=1", addr_D); end
      for (int i = 0; i < 4; i++) begin
         nextCycle();
         mdu_valid = 0;
         wb_rd = 5'(2 + i); wb_data = 32'h200 + 32'(i);
         #1;
         checks++; if (addr_D !== 5'(2 + i) || data_D !== 32'h200 + 32'(i) || wb_hold !== 1'b0) begin
            failures++; $display("[TB] FAIL starve_wb%0d got=%0d/%0h/%0b exp=%0d/%0h/0", i, addr_D, data_D, wb_hold, 2 + i, 32'h200 + 32'(i));
         end
      end
      nextCycle();
      wb_rd = 5'd20; wb_data = 32'h2020;
      #1;
      checks++; if (addr_D !== 5'd3 || data_D !== 32'h33) begin failures++; $display("[TB] FAIL starve_fifo got=%0d/%0h exp=3/33", addr_D, data_D); end
      checks++; if (wb_hold !== 1'b1) begin failures++; $display("[TB] FAIL starve_hold got=%0b exp=1", wb_hold); end
      nextCycle();
      #1;
      checks++; if (addr_D !== 5'd20 || wb_hold !== 1'b0) begin failures++; $display("[TB] FAIL starve_resume got=%0d/%0b exp=20/0", addr_D, wb_hold); end
      clearInputs();
   endtask

   task automatic test_full();
      nextCycle();
      wb_valid = 1; wb_rd = 5'd1; mdu_valid = 1; mdu_rd = 5'd10; mdu_data = 32'hA;
      #1;
      checks++; if (mdu_ready !== 1'b1 || addr_D !== 5'd1) begin failures++; $display("[TB] FAIL full_c0 got=%0b/%0d exp=1/1", mdu_ready, addr_D); end
      nextCycle();
      wb_rd = 5'd2; mdu_rd = 5'd11; mdu_data = 32'hB;
      #1;
      checks++; if (mdu_ready !== 1'b1 || fifo_count !== 2'd1) begin failures++; $display("[TB] FAIL full_c1 got=%0b/%0d exp=1/1", mdu_ready, fifo_count); end
      nextCycle();
      wb_rd = 5'd3; mdu_rd = 5'd12; mdu_data = 32'hC;
      #1;
      checks++; if (mdu_ready !== 1'b0 || fifo_count !== 2'd2 || addr_D !== 5'd3) begin failures++; $display("[TB] FAIL full_c2 got=%0b/%0d/%0d exp=0/2/3", mdu_ready, fifo_count, addr_D); end
      nextCycle();
      wb_valid = 0; mdu_valid = 0;
      #1;
      checks++; if (addr_D !== 5'd10 || data_D !== 32'hA) begin failures++; $display("[TB] FAIL full_pop10 got=%0d/%0h exp=10/a", addr_D, data_D); end
      nextCycle();
      mdu_valid = 1; mdu_rd = 5'd12; mdu_data = 32'hC;
      #1;
      checks++; if (mdu_ready !== 1'b1 || addr_D !== 5'd11 || data_D !== 32'hB) begin failures++; $display("[TB] FAIL full_pop11 got=%0b/%0d/%0h exp=1/11/b", mdu_ready, addr_D, data_D); end
      nextCycle();
      mdu_valid = 0;
      #1;
      checks++; if (fifo_count !== 2'd1 || addr_D !== 5'd12 || data_D !== 32'hC) begin failures++; $display("[TB] FAIL full_pushpop got=%0d/%0d/%0h exp=1/12/c", fifo_count, addr_D, data_D); end
      nextCycle();
      #1;
      checks++; if (fifo_count !== 2'd0 || regWEn !== 1'b0) begin failures++; $display("[TB] FAIL full_drain got=%0d/%0b exp=0/0", fifo_count, regWEn); end
      clearInputs();
   endtask

   task automatic test_x0();
      nextCycle();
      wb_valid = 1; wb_rd = 5'd0; wb_data = 32'hBAD;
      mdu_valid = 1; mdu_rd = 5'd0; mdu_data = 32'hBAD0;
      #1;
      checks++; if (regWEn !== 1'b0 || wb_hold !== 1'b0) begin failures++; $display("[TB] FAIL x0_wen got=%0b/%0b exp=0/0", regWEn, wb_hold); end
      nextCycle();
      mdu_rd = 5'd4; mdu_data = 32'h44;
      #1;
      checks++; if (fifo_count !== 2'd0 || regWEn !== 1'b0) begin failures++; $display("[TB] FAIL x0_drop got=%0d/%0b exp=0/0", fifo_count, regWEn); end
      nextCycle();
      mdu_valid = 0;
      #1;
      checks++; if (regWEn !== 1'b1 || addr_D !== 5'd4 || data_D !== 32'h44 || wb_hold !== 1'b0) begin
         failures++; $display("[TB] FAIL x0_slot got=%0b/%0d/%0h/%0b exp=1/4/44/0", regWEn, addr_D, data_D, wb_hold);
      end
      clearInputs();
   endtask

   task automatic test_reset_mid();
      nextCycle();
      issue_valid = 1; issue_rd = 5'd6;
      mdu_valid = 1; mdu_rd = 5'd8; mdu_data = 32'h88;
      nextCycle();
      issue_valid = 0; mdu_valid = 0; id_rs1 = 5'd6;
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (regWEn !== 1'b0) begin failures++; $display("[TB] FAIL rmid_wen got=%0b exp=0", regWEn); end
      checks++; if (mdu_ready !== 1'b1 || fifo_count !== 2'd0) begin failures++; $display("[TB] FAIL rmid_fifo got=%0b/%0d exp=1/0", mdu_ready, fifo_count); end
      checks++; if (id_stall !== 1'b0) begin failures++; $display("[TB] FAIL rmid_stall got=%0b exp=0", id_stall); end
      @(negedge clock);
      rst_n = 1'b1;
      nextCycle();
      #1;
      checks++; if (regWEn !== 1'b0 || id_stall !== 1'b0) begin failures++; $display("[TB] FAIL rmid_after got=%0b/%0b exp=0/0", regWEn, id_stall); end
      clearInputs();
   endtask

   // Run every scenario in sequence, then print the summary.
   initial begin
      test_reset();
      test_mdu_push();
      test_scoreboard();
      test_starvation();
      test_full();
      test_x0();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
